// File: rtl/reorder_buffer.sv
// reorder_buffer: in-order retirement queue; define QU_ROB_EXCEPTION_EN to enable exception-at-retire flush
module reorder_buffer #(
  parameter int ROB_DEPTH         = 16,
  parameter int PHY_RF_ADDR_WIDTH = 6,
  parameter int PC_WIDTH          = 32
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          flush,
  input  logic                          rob_incr_tail_ptr,
  input  logic                          alloc_rd_valid,
  input  logic [PHY_RF_ADDR_WIDTH-1:0]  alloc_phy_rd,
  input  logic [PC_WIDTH-1:0]           alloc_pc,
  output logic [$clog2(ROB_DEPTH)-1:0]  rob_tail_ptr,
  output logic                          rob_full,
  output logic                          rob_empty,
  input  logic                          cmp_en,
  input  logic [$clog2(ROB_DEPTH)-1:0]  cmp_addr,
  input  logic                          cmp_exception,
  output logic                          busy_table_wr_en,
  output logic [PHY_RF_ADDR_WIDTH-1:0]  busy_table_wr_addr,
  output logic                          busy_table_wr_data,
  output logic                          exception_out,
  output logic [PC_WIDTH-1:0]           exception_pc
);
  localparam int AW = $clog2(ROB_DEPTH);
  typedef logic [AW-1:0] rob_addr_t;
  typedef logic [AW:0]   rob_cnt_t;
`ifdef QU_ROB_EXCEPTION_EN
  localparam bit EXC_EN = 1'b1;
`else
  localparam bit EXC_EN = 1'b0;
`endif
  logic [ROB_DEPTH-1:0]         valid, done, exc, rd_valid;
  logic [PHY_RF_ADDR_WIDTH-1:0] phy_rd [ROB_DEPTH];
  logic [PC_WIDTH-1:0]          pc [ROB_DEPTH];
  rob_addr_t                    head, tail;
  rob_cnt_t                     count, count_nxt;
  logic                         alloc, retire, take_exc, clear, bt_wr, exc_fire;
  assign rob_tail_ptr       = tail;
  assign busy_table_wr_data = 1'b0;
  // retire decision on the head entry, exception gating and next occupancy
  always_comb begin
    alloc     = rob_incr_tail_ptr & ~rob_full;
    retire    = valid[head] & done[head];
    take_exc  = retire & exc[head] & EXC_EN;
    clear     = flush | take_exc;
    bt_wr     = retire & ~clear & rd_valid[head];
    exc_fire  = take_exc & ~flush;
    count_nxt = clear ? '0 : count + rob_cnt_t'(alloc) - rob_cnt_t'(retire);
  end
  // payload written at allocation; valid bits guard every read
  always_ff @(posedge clk) begin
    if (alloc) begin
      rd_valid[tail] <= alloc_rd_valid;
      phy_rd[tail]   <= alloc_phy_rd;
      pc[tail]       <= alloc_pc;
    end
  end
  // entry status: completion, allocation, retirement; flush wipes all valid bits
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= '0;
      done  <= '0;
      exc   <= '0;
    end else if (clear) begin
      valid <= '0;
    end else begin
      if (cmp_en && valid[cmp_addr]) begin
        done[cmp_addr] <= 1'b1;
        exc[cmp_addr]  <= cmp_exception & EXC_EN;
      end
      if (alloc) begin
        valid[tail] <= 1'b1;
        done[tail]  <= 1'b0;
        exc[tail]   <= 1'b0;
      end
      if (retire) valid[head] <= 1'b0;
    end
  end
  // pointers, occupancy flags and registered retire outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head               <= '0;
      tail               <= '0;
      count              <= '0;
      rob_full           <= 1'b0;
      rob_empty          <= 1'b1;
      busy_table_wr_en   <= 1'b0;
      busy_table_wr_addr <= '0;
      exception_out      <= 1'b0;
      exception_pc       <= '0;
    end else begin
      head               <= clear ? '0 : head + rob_addr_t'(retire);
      tail               <= clear ? '0 : tail + rob_addr_t'(alloc);
      count              <= count_nxt;
      rob_full           <= count_nxt == rob_cnt_t'(ROB_DEPTH);
      rob_empty          <= count_nxt == '0;
      busy_table_wr_en   <= bt_wr;
      busy_table_wr_addr <= bt_wr ? phy_rd[head] : '0;
      exception_out      <= exc_fire;
      exception_pc       <= exc_fire ? pc[head] : '0;
    end
  end
endmodule

// File: tb/tb_reorder_buffer.sv
// tb_reorder_buffer: queue-model checked directed and random test of reorder_buffer
module tb_reorder_buffer;
  localparam int D = 16;
`ifdef QU_ROB_EXCEPTION_EN
  localparam bit EXC = 1'b1;
`else
  localparam bit EXC = 1'b0;
`endif
  logic        clk = 1'b0, rst = 1'b1, flush = 1'b0, rob_incr_tail_ptr = 1'b0, alloc_rd_valid = 1'b0;
  logic [5:0]  alloc_phy_rd = '0;
  logic [31:0] alloc_pc = '0;
  logic [3:0]  rob_tail_ptr;
  logic        rob_full, rob_empty;
  logic        cmp_en = 1'b0, cmp_exception = 1'b0;
  logic [3:0]  cmp_addr = '0;
  logic        busy_table_wr_en, busy_table_wr_data, exception_out;
  logic [5:0]  busy_table_wr_addr;
  logic [31:0] exception_pc;
  int n_checks = 0, n_err = 0;

  reorder_buffer #(.ROB_DEPTH(D), .PHY_RF_ADDR_WIDTH(6), .PC_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .flush(flush), .rob_incr_tail_ptr(rob_incr_tail_ptr),
    .alloc_rd_valid(alloc_rd_valid), .alloc_phy_rd(alloc_phy_rd), .alloc_pc(alloc_pc),
    .rob_tail_ptr(rob_tail_ptr), .rob_full(rob_full), .rob_empty(rob_empty),
    .cmp_en(cmp_en), .cmp_addr(cmp_addr), .cmp_exception(cmp_exception),
    .busy_table_wr_en(busy_table_wr_en), .busy_table_wr_addr(busy_table_wr_addr),
    .busy_table_wr_data(busy_table_wr_data), .exception_out(exception_out),
    .exception_pc(exception_pc)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit        rdv;
    bit [5:0]  phy;
    bit [31:0] pc;
    bit        done;
    bit        exc;
  } ent_t;
  ent_t        q[$];
  int          m_head = 0;
  bit          e_en = 0, e_exo = 0;
  bit [5:0]    e_addr = '0;
  bit [31:0]   e_pc = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", nm, $time, act, exp);
    end
  endtask

  // program-order model: a queue of live uops; slot index = (head + position) mod D
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      q.delete(); m_head = 0; e_en = 0; e_addr = '0; e_exo = 0; e_pc = '0;
    end else begin
      bit ret, ex, was_full;
      int idx;
      ent_t n;
      ret = q.size() > 0 && q[0].done;
      ex = EXC && ret && q[0].exc;
      was_full = q.size() == D;
      if (flush) begin
        q.delete(); m_head = 0; e_en = 0; e_addr = '0; e_exo = 0; e_pc = '0;
      end else begin
        e_en = ret && !ex && q[0].rdv;
        e_addr = e_en ? q[0].phy : 6'd0;
        e_exo = ex;
        e_pc = ex ? q[0].pc : 32'd0;
        if (cmp_en) begin
          idx = (int'(cmp_addr) - m_head + D) % D;
          if (idx < q.size()) begin
            q[idx].done = 1;
            q[idx].exc = cmp_exception;
          end
        end
        if (ex) begin
          q.delete(); m_head = 0;
        end else begin
          if (ret) begin
            void'(q.pop_front());
            m_head = (m_head + 1) % D;
          end
          if (rob_incr_tail_ptr && !was_full) begin
            n.rdv = alloc_rd_valid; n.phy = alloc_phy_rd; n.pc = alloc_pc; n.done = 0; n.exc = 0;
            q.push_back(n);
          end
        end
      end
    end
  end

  // every-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    chk("tail_ptr", 32'(rob_tail_ptr), 32'((m_head + q.size()) % D));
    chk("full", 32'(rob_full), 32'(q.size() == D));
    chk("empty", 32'(rob_empty), 32'(q.size() == 0));
    chk("bt_wr_en", 32'(busy_table_wr_en), 32'(e_en));
    if (e_en) chk("bt_wr_addr", 32'(busy_table_wr_addr), 32'(e_addr));
    chk("bt_wr_data", 32'(busy_table_wr_data), 32'd0);
    chk("exc_out", 32'(exception_out), 32'(e_exo));
    chk("exc_pc", exception_pc, e_pc);
  end

  task automatic step(input bit inc, input bit rdv, input logic [5:0] phy, input logic [31:0] pc,
                      input bit ce, input logic [3:0] ca, input bit cx, input bit fl);
    rob_incr_tail_ptr = inc; alloc_rd_valid = rdv; alloc_phy_rd = phy; alloc_pc = pc;
    cmp_en = ce; cmp_addr = ca; cmp_exception = cx; flush = fl;
    @(negedge clk);
  endtask

  task automatic idle();
    step(0, 0, 6'd0, 32'd0, 0, 4'd0, 0, 0);
  endtask

  initial begin
    @(negedge clk);
    chk("rst_empty", 32'(rob_empty), 32'd1);
    chk("rst_tail", 32'(rob_tail_ptr), 32'd0);
    chk("rst_full", 32'(rob_full), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    // allocate and retire one entry
    step(1, 1, 6'd7, 32'h40, 0, 4'd0, 0, 0);
    chk("t1_tail", 32'(rob_tail_ptr), 32'd1);
    step(0, 0, 6'd0, 32'd0, 1, 4'd0, 0, 0);
    chk("t1_no_early_wr", 32'(busy_table_wr_en), 32'd0);
    idle();
    chk("t1_wr_en", 32'(busy_table_wr_en), 32'd1);
    chk("t1_wr_addr", 32'(busy_table_wr_addr), 32'd7);
    chk("t1_empty", 32'(rob_empty), 32'd1);
    idle();
    chk("t1_wr_pulse", 32'(busy_table_wr_en), 32'd0);
    // fill to full, then an ignored 17th allocate
    for (int i = 0; i < D; i++) step(1, 1, 6'(i), 32'(i * 4), 0, 4'd0, 0, 0);
    chk("t2_full", 32'(rob_full), 32'd1);
    chk("t2_tail", 32'(rob_tail_ptr), 32'd1);
    step(1, 1, 6'd63, 32'h0, 0, 4'd0, 0, 0);
    chk("t2_still_full", 32'(rob_full), 32'd1);
    chk("t2_tail_held", 32'(rob_tail_ptr), 32'd1);
    step(0, 0, 6'd0, 32'd0, 0, 4'd0, 0, 1);
    chk("t2_flush_empty", 32'(rob_empty), 32'd1);
    // out-of-order completion, in-order retirement
    for (int i = 0; i < 3; i++) step(1, 1, 6'(10 + i), 32'd0, 0, 4'd0, 0, 0);
    step(0, 0, 6'd0, 32'd0, 1, 4'd2, 0, 0);
    step(0, 0, 6'd0, 32'd0, 1, 4'd1, 0, 0);
    chk("t3_hold_1", 32'(busy_table_wr_en), 32'd0);
    step(0, 0, 6'd0, 32'd0, 1, 4'd0, 0, 0);
    chk("t3_hold_0", 32'(busy_table_wr_en), 32'd0);
    for (int i = 0; i < 3; i++) begin
      idle();
      chk("t3_ret_en", 32'(busy_table_wr_en), 32'd1);
      chk("t3_ret_addr", 32'(busy_table_wr_addr), 32'(10 + i));
    end
    idle();
    chk("t3_done_en", 32'(busy_table_wr_en), 32'd0);
    chk("t3_empty", 32'(rob_empty), 32'd1);
    // pointer wrap with no destination registers
    step(0, 0, 6'd0, 32'd0, 0, 4'd0, 0, 1);
    for (int i = 0; i < 20; i++) begin
      step(1, 0, 6'($urandom), 32'd0, 0, 4'd0, 0, 0);
      step(0, 0, 6'd0, 32'd0, 1, 4'(i % D), 0, 0);
    end
    idle();
    chk("t4_tail", 32'(rob_tail_ptr), 32'd4);
    chk("t4_empty", 32'(rob_empty), 32'd1);
    // flush overrides allocate, completion and a pending retire
    step(0, 0, 6'd0, 32'd0, 0, 4'd0, 0, 1);
    for (int i = 0; i < 5; i++) step(1, 1, 6'(20 + i), 32'd0, 0, 4'd0, 0, 0);
    step(0, 0, 6'd0, 32'd0, 1, 4'd0, 0, 0);
    step(1, 1, 6'd30, 32'd0, 1, 4'd1, 0, 1);
    chk("t5_tail", 32'(rob_tail_ptr), 32'd0);
    chk("t5_empty", 32'(rob_empty), 32'd1);
    chk("t5_no_wr", 32'(busy_table_wr_en), 32'd0);
`ifdef QU_ROB_EXCEPTION_EN
    // exception at head flushes younger entries
    for (int i = 0; i < 3; i++) step(1, 1, 6'(1 + i), 32'h100 + 32'(i * 4), 0, 4'd0, 0, 0);
    step(0, 0, 6'd0, 32'd0, 1, 4'd0, 1, 0);
    idle();
    chk("t6_exc_out", 32'(exception_out), 32'd1);
    chk("t6_exc_pc", exception_pc, 32'h100);
    chk("t6_no_wr", 32'(busy_table_wr_en), 32'd0);
    chk("t6_empty", 32'(rob_empty), 32'd1);
    idle();
    chk("t6_pulse", 32'(exception_out), 32'd0);
`endif
    // random traffic, with an asynchronous reset midway
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) begin
        #2 rst = 1'b1;
        #1;
        chk("arst_tail", 32'(rob_tail_ptr), 32'd0);
        chk("arst_empty", 32'(rob_empty), 32'd1);
        chk("arst_wr_en", 32'(busy_table_wr_en), 32'd0);
        @(negedge clk);
        rst = 1'b0;
      end
      step($urandom_range(0, 9) < 7, 1'($urandom), 6'($urandom), $urandom,
           1'($urandom), 4'($urandom), $urandom_range(0, 9) == 0, $urandom_range(0, 49) == 0);
    end
    idle();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule
